// File: rtl/lfsr_pkg.sv
// ============================================================================
// Module   : lfsr_pkg
// Brief    : Shared constants for lfsr_generator: default seed and
//            maximal-length Fibonacci tap masks for widths 3..32.
// Revision : 1.0
// ============================================================================
`default_nettype none

package lfsr_pkg;

  localparam logic [31:0] c_default_seed = 32'd1;
  localparam int          c_min_width    = 3;
  localparam int          c_max_width    = 32;

  // Taps are given as 1-based polynomial exponents; zero means unused.
  function automatic logic [31:0] tap_mask(input int a, input int b, input int c, input int d);
    logic [31:0] m;
    m = '0;
    if (a > 0) m = m | (32'd1 << (a - 1));
    if (b > 0) m = m | (32'd1 << (b - 1));
    if (c > 0) m = m | (32'd1 << (c - 1));
    if (d > 0) m = m | (32'd1 << (d - 1));
    return m;
  endfunction

  function automatic logic [31:0] default_taps(input int width);
    case (width)
      3:       return tap_mask(3, 2, 0, 0);
      4:       return tap_mask(4, 3, 0, 0);
      5:       return tap_mask(5, 3, 0, 0);
      6:       return tap_mask(6, 5, 0, 0);
      7:       return tap_mask(7, 6, 0, 0);
      8:       return tap_mask(8, 6, 5, 4);
      9:       return tap_mask(9, 5, 0, 0);
      10:      return tap_mask(10, 7, 0, 0);
      11:      return tap_mask(11, 9, 0, 0);
      12:      return tap_mask(12, 6, 4, 1);
      13:      return tap_mask(13, 4, 3, 1);
      14:      return tap_mask(14, 5, 3, 1);
      15:      return tap_mask(15, 14, 0, 0);
      16:      return tap_mask(16, 15, 13, 4);
      17:      return tap_mask(17, 14, 0, 0);
      18:      return tap_mask(18, 11, 0, 0);
      19:      return tap_mask(19, 6, 2, 1);
      20:      return tap_mask(20, 17, 0, 0);
      21:      return tap_mask(21, 19, 0, 0);
      22:      return tap_mask(22, 21, 0, 0);
      23:      return tap_mask(23, 18, 0, 0);
      24:      return tap_mask(24, 23, 22, 17);
      25:      return tap_mask(25, 22, 0, 0);
      26:      return tap_mask(26, 6, 2, 1);
      27:      return tap_mask(27, 5, 2, 1);
      28:      return tap_mask(28, 25, 0, 0);
      29:      return tap_mask(29, 27, 0, 0);
      30:      return tap_mask(30, 6, 4, 1);
      31:      return tap_mask(31, 28, 0, 0);
      32:      return tap_mask(32, 22, 2, 1);
      default: return '0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/lfsr_step.sv
// ============================================================================
// Module   : lfsr_step
// Brief    : One combinational Fibonacci LFSR step (XOR taps, shift left).
// Revision : 1.0
// ============================================================================
`default_nettype none

module lfsr_step #(
  parameter int              WIDTH = 5,
  parameter logic [WIDTH-1:0] TAPS = '0
) (
  input  logic [WIDTH-1:0] i_state,
  output logic [WIDTH-1:0] o_state
);

  logic w_fb;

  assign w_fb    = ^(i_state & TAPS);
  assign o_state = {i_state[WIDTH-2:0], w_fb};

endmodule

`default_nettype wire

// File: rtl/lfsr_generator.sv
// ============================================================================
// Module   : lfsr_generator
// Brief    : Multi-step Fibonacci LFSR with runtime seed load, lock-up
//            recovery, wrap detection and a saturating step counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lfsr_generator
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 5,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(c_default_seed),
  parameter int               STEPS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] lfsr,
  output logic             bit_out,
  output logic             wrap,
  output logic [WIDTH:0]   step_cnt
);

  if (WIDTH < c_min_width || WIDTH > c_max_width) begin : g_bad_width
    $error("lfsr_generator: WIDTH=%0d outside 3..32", WIDTH);
  end

  if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
    $error("lfsr_generator: STEPS=%0d outside 1..WIDTH", STEPS);
  end

  logic [WIDTH-1:0] r_lfsr;
  logic [WIDTH-1:0] r_seed;
  logic [WIDTH:0]   r_cnt;
  logic             r_wrap;

  logic [WIDTH-1:0] w_chain [0:STEPS];
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH:0]   w_cnt_inc;

  assign w_chain[0] = r_lfsr;

  for (genvar gi = 0; gi < STEPS; gi++) begin : g_step
    lfsr_step #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS)
    ) u_step (
      .i_state (w_chain[gi]),
      .o_state (w_chain[gi+1])
    );
  end

  assign w_next = w_chain[STEPS];

  // A zero seed would lock the register, so it is replaced by SEED.
  assign w_load_val = (seed_in == '0) ? SEED : seed_in;
  assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + {{WIDTH{1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lfsr <= SEED;
      r_seed <= SEED;
      r_cnt  <= '0;
      r_wrap <= 1'b0;
    end else if (load) begin
      r_lfsr <= w_load_val;
      r_seed <= w_load_val;
      r_cnt  <= '0;
      r_wrap <= 1'b0;
    end else if (en) begin
      if (r_lfsr == '0) begin
        // Recovery from lock-up is not a wrap, even though it lands on the seed.
        r_lfsr <= r_seed;
        r_cnt  <= w_cnt_inc;
        r_wrap <= 1'b0;
      end else if (w_next == r_seed) begin
        r_lfsr <= w_next;
        r_cnt  <= '0;
        r_wrap <= 1'b1;
      end else begin
        r_lfsr <= w_next;
        r_cnt  <= w_cnt_inc;
        r_wrap <= 1'b0;
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign lfsr     = r_lfsr;
  assign bit_out  = r_lfsr[WIDTH-1];
  assign wrap     = r_wrap;
  assign step_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_lfsr_generator.sv
// ============================================================================
// Module   : tb_lfsr_generator
// Brief    : Scoreboard bench for lfsr_generator: default, two-step and
//            zero-tap (lock-up / saturation) instances driven in parallel.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lfsr_generator;

  typedef struct packed {
    logic [4:0] lfsr;
    logic [4:0] seed;
    logic [5:0] cnt;
    logic       wrap;
  } st_t;

  typedef struct packed {
    st_t a;
    st_t b;
    st_t c;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       en;
  logic       load;
  logic [4:0] seed_in;

  logic [4:0] lfsr1, lfsr2, lfsr3;
  logic       bit1, bit2, bit3;
  logic       wrap1, wrap2, wrap3;
  logic [5:0] cnt1, cnt2, cnt3;

  int   total;
  int   bad;
  st_t  m1, m2, m3;
  exp_t q [$];

  logic [4:0] tab1 [0:4];
  logic [4:0] tab2 [0:2];

  lfsr_generator u_dut1 (
    .clk(clk), .reset(reset), .en(en), .load(load), .seed_in(seed_in),
    .lfsr(lfsr1), .bit_out(bit1), .wrap(wrap1), .step_cnt(cnt1)
  );

  lfsr_generator #(.STEPS(2)) u_dut2 (
    .clk(clk), .reset(reset), .en(en), .load(load), .seed_in(seed_in),
    .lfsr(lfsr2), .bit_out(bit2), .wrap(wrap2), .step_cnt(cnt2)
  );

  // Zero taps drain the register to all-zero, exercising recovery and saturation.
  lfsr_generator #(.TAPS(5'b00000)) u_dut3 (
    .clk(clk), .reset(reset), .en(en), .load(load), .seed_in(seed_in),
    .lfsr(lfsr3), .bit_out(bit3), .wrap(wrap3), .step_cnt(cnt3)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic st_t model(input st_t s, input logic [4:0] taps, input int steps,
                                input logic r, input logic l, input logic e, input logic [4:0] sin);
    st_t        n;
    logic [4:0] v;
    logic       fb;
    n      = s;
    n.wrap = 1'b0;
    if (r) begin
      n.lfsr = 5'd1;
      n.seed = 5'd1;
      n.cnt  = 6'd0;
    end else if (l) begin
      v      = (sin == 5'd0) ? 5'd1 : sin;
      n.lfsr = v;
      n.seed = v;
      n.cnt  = 6'd0;
    end else if (e) begin
      if (s.lfsr == 5'd0) begin
        n.lfsr = s.seed;
        n.cnt  = (s.cnt == 6'd63) ? 6'd63 : s.cnt + 6'd1;
      end else begin
        v = s.lfsr;
        for (int k = 0; k < steps; k++) begin
          fb = ^(v & taps);
          v  = {v[3:0], fb};
        end
        n.lfsr = v;
        if (v == s.seed) begin
          n.wrap = 1'b1;
          n.cnt  = 6'd0;
        end else begin
          n.cnt  = (s.cnt == 6'd63) ? 6'd63 : s.cnt + 6'd1;
        end
      end
    end
    return n;
  endfunction

  task automatic cycle(input logic r, input logic l, input logic e, input logic [4:0] s);
    exp_t x;
    reset   = r;
    load    = l;
    en      = e;
    seed_in = s;
    m1 = model(m1, 5'b10100, 1, r, l, e, s);
    m2 = model(m2, 5'b10100, 2, r, l, e, s);
    m3 = model(m3, 5'b00000, 1, r, l, e, s);
    q.push_back('{m1, m2, m3});
    @(posedge clk);
    #1;
    x = q.pop_front();
    check_val("d1_lfsr", 32'(lfsr1), 32'(x.a.lfsr));
    check_val("d1_bit",  32'(bit1),  32'(x.a.lfsr[4]));
    check_val("d1_wrap", 32'(wrap1), 32'(x.a.wrap));
    check_val("d1_cnt",  32'(cnt1),  32'(x.a.cnt));
    check_val("d2_lfsr", 32'(lfsr2), 32'(x.b.lfsr));
    check_val("d2_bit",  32'(bit2),  32'(x.b.lfsr[4]));
    check_val("d2_wrap", 32'(wrap2), 32'(x.b.wrap));
    check_val("d2_cnt",  32'(cnt2),  32'(x.b.cnt));
    check_val("d3_lfsr", 32'(lfsr3), 32'(x.c.lfsr));
    check_val("d3_bit",  32'(bit3),  32'(x.c.lfsr[4]));
    check_val("d3_wrap", 32'(wrap3), 32'(x.c.wrap));
    check_val("d3_cnt",  32'(cnt3),  32'(x.c.cnt));
  endtask

  initial begin
    int pulses1, pulses2, at1, at2;
    total   = 0;
    bad     = 0;
    clk     = 1'b0;
    reset   = 1'b1;
    load    = 1'b0;
    en      = 1'b0;
    seed_in = 5'd0;
    m1      = '0;
    m2      = '0;
    m3      = '0;
    tab1    = '{5'b00010, 5'b00100, 5'b01001, 5'b10010, 5'b00101};
    tab2    = '{5'b00100, 5'b10010, 5'b01011};

    cycle(1'b1, 1'b0, 1'b0, 5'd0);
    cycle(1'b1, 1'b0, 1'b0, 5'd0);
    check_val("rst_lfsr", 32'(lfsr1), 32'd1);
    check_val("rst_cnt",  32'(cnt1),  32'd0);
    check_val("rst_wrap", 32'(wrap1), 32'd0);

    // Full period from reset with en held high.
    pulses1 = 0; pulses2 = 0; at1 = 0; at2 = 0;
    for (int i = 0; i < 31; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 5'd0);
      if (i < 5) check_val("seq1", 32'(lfsr1), 32'(tab1[i]));
      if (i < 3) check_val("seq2", 32'(lfsr2), 32'(tab2[i]));
      if (wrap1) begin pulses1++; at1 = i + 1; end
      if (wrap2) begin pulses2++; at2 = i + 1; end
    end
    check_val("wrap1_pulses", 32'(pulses1), 32'd1);
    check_val("wrap1_at",     32'(at1),     32'd31);
    check_val("wrap1_lfsr",   32'(lfsr1),   32'd1);
    check_val("wrap1_cnt",    32'(cnt1),    32'd0);
    check_val("wrap2_pulses", 32'(pulses2), 32'd1);
    check_val("wrap2_at",     32'(at2),     32'd31);

    cycle(1'b0, 1'b0, 1'b0, 5'd0);
    cycle(1'b0, 1'b0, 1'b1, 5'd0);
    cycle(1'b0, 1'b0, 1'b0, 5'd0);
    check_val("hold_lfsr", 32'(lfsr1), 32'b00010);

    cycle(1'b0, 1'b1, 1'b0, 5'b00000);
    check_val("load0_lfsr", 32'(lfsr1), 32'b00001);
    check_val("load0_cnt",  32'(cnt1),  32'd0);

    cycle(1'b0, 1'b1, 1'b1, 5'b10110);
    check_val("loaden_lfsr", 32'(lfsr1), 32'b10110);
    cycle(1'b0, 1'b0, 1'b1, 5'd0);
    check_val("loaden_next", 32'(lfsr1), 32'b01100);

    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 31)));
    end

    cycle(1'b0, 1'b0, 1'b1, 5'd0);
    cycle(1'b1, 1'b1, 1'b1, 5'b10110);
    check_val("midrst_lfsr", 32'(lfsr1), 32'd1);
    check_val("midrst_cnt",  32'(cnt1),  32'd0);

    for (int i = 0; i < 70; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 5'd0);
    end
    check_val("sat_cnt", 32'(cnt3), 32'd63);

    check_val("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
